// File: rtl/tw_addr_gen.sv
// Twiddle-address sequencer for one R2^2 SDF FFT stage: tracks sample position in the
// sub-FFT, forms the twiddle exponent and drives the combinational twiddle ROM address.
module tw_addr_gen #(
  parameter int N_LOG     = 9,
  parameter int STAGE     = 0,
  parameter int DEPTH_LOG = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_sof,
  input  logic                 i_inverse,
  output logic [DEPTH_LOG-1:0] o_rom_addr,
  output logic                 o_valid,
  output logic                 o_trivial,
  output logic                 o_sof,
  output logic                 o_eof,
  output logic                 o_sof_err
);

  localparam int L_LOG = N_LOG - 2 * STAGE;
  localparam int SHIFT = 2 * STAGE;

  generate
    if (L_LOG < 4) begin : g_bad_stage
      $error("tw_addr_gen: sub-FFT size log2 (N_LOG - 2*STAGE) must be at least 4");
    end
    if (DEPTH_LOG != N_LOG) begin : g_bad_depth
      $error("tw_addr_gen: DEPTH_LOG must equal N_LOG");
    end
  endgenerate

  logic [L_LOG-1:0]     cnt;
  logic [L_LOG-1:0]     c_eff;
  logic [1:0]           q;
  logic [L_LOG-3:0]     r;
  logic [L_LOG-1:0]     r_ext;
  logic [L_LOG-1:0]     e;
  logic [DEPTH_LOG-1:0] a;
  logic [DEPTH_LOG-1:0] addr;
  logic                 inv_lat;
  logic                 inv_eff;

  always_comb begin
    c_eff = i_sof ? '0 : cnt;
    q     = c_eff[L_LOG-1 -: 2];
    r     = c_eff[L_LOG-3:0];
    r_ext = L_LOG'(r);
    // Multiplier k(q) is the bit-reversed quadrant, so e = r*{0,2,1,3} via shift/add
    unique case (q)
      2'd0:    e = '0;
      2'd1:    e = r_ext << 1;
      2'd2:    e = r_ext;
      default: e = r_ext + (r_ext << 1);
    endcase
    a       = DEPTH_LOG'(e) << SHIFT;
    inv_eff = (c_eff == '0) ? i_inverse : inv_lat;
    addr    = inv_eff ? -a : a;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt        <= '0;
      inv_lat    <= 1'b0;
      o_rom_addr <= '0;
      o_valid    <= 1'b0;
      o_trivial  <= 1'b0;
      o_sof      <= 1'b0;
      o_eof      <= 1'b0;
      o_sof_err  <= 1'b0;
    end else begin
      o_valid   <= i_valid;
      o_sof     <= i_valid & (c_eff == '0);
      o_eof     <= i_valid & (c_eff == '1);
      o_sof_err <= i_valid & i_sof & (cnt != '0);
      if (i_valid) begin
        cnt        <= c_eff + 1'b1;
        o_rom_addr <= addr;
        o_trivial  <= (e == '0);
        if (c_eff == '0) inv_lat <= i_inverse;
      end
    end
  end

endmodule

// File: tb/tb_tw_addr_gen.sv
// Bench for tw_addr_gen: N=16/STAGE=0 and N=64/STAGE=1 instances share stimulus (both L=16).
module tb_tw_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       sof = 1'b0;
  logic       inv = 1'b0;
  logic [3:0] a4;
  logic [5:0] a6;
  logic       v4, t4, s4, e4, er4;
  logic       v6, t6, s6, e6, er6;

  tw_addr_gen #(.N_LOG(4), .STAGE(0), .DEPTH_LOG(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sof(sof), .i_inverse(inv),
    .o_rom_addr(a4), .o_valid(v4), .o_trivial(t4), .o_sof(s4), .o_eof(e4), .o_sof_err(er4)
  );

  tw_addr_gen #(.N_LOG(6), .STAGE(1), .DEPTH_LOG(6)) u_dut6 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sof(sof), .i_inverse(inv),
    .o_rom_addr(a6), .o_valid(v6), .o_trivial(t6), .o_sof(s6), .o_eof(e6), .o_sof_err(er6)
  );

  typedef struct {
    logic       valid;
    logic [3:0] addr4;
    logic [5:0] addr6;
    logic       trivial;
    logic       sof;
    logic       eof;
    logic       err;
  } exp_t;

  typedef struct {
    logic       sof;
    logic [3:0] addr;
    logic       trivial;
    logic       eof;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned m_c;
  logic        m_inv;
  exp_t        m_prev;
  vec_t        tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_c    = 0;
    m_inv  = 1'b0;
    m_prev = '{default: 0};
  endtask

  task automatic model_step(input logic v, input logic s, input logic iv, output exp_t x);
    int unsigned ce, q, r, k, e;
    x       = m_prev;
    x.valid = 1'b0;
    x.sof   = 1'b0;
    x.eof   = 1'b0;
    x.err   = 1'b0;
    if (v) begin
      x.err = s && (m_c != 0);
      ce    = s ? 0 : m_c;
      if (ce == 0) m_inv = iv;
      q = ce / 4;
      r = ce % 4;
      k = (q == 1) ? 2 : (q == 2) ? 1 : q;
      e = r * k;
      x.valid   = 1'b1;
      x.trivial = (e == 0);
      x.sof     = (ce == 0);
      x.eof     = (ce == 15);
      x.addr4   = m_inv ? 4'((16 - e) % 16) : 4'(e);
      x.addr6   = m_inv ? 6'((64 - e * 4) % 64) : 6'(e * 4);
      m_c       = (ce + 1) % 16;
    end
    m_prev = x;
  endtask

  task automatic check_out();
    exp_t x;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    x = sb.pop_front();
    chk("valid4", v4, x.valid);
    chk("addr4", a4, x.addr4);
    chk("trivial4", t4, x.trivial);
    chk("sof4", s4, x.sof);
    chk("eof4", e4, x.eof);
    chk("err4", er4, x.err);
    chk("valid6", v6, x.valid);
    chk("addr6", a6, x.addr6);
    chk("trivial6", t6, x.trivial);
    chk("sof6", s6, x.sof);
    chk("eof6", e6, x.eof);
    chk("err6", er6, x.err);
  endtask

  task automatic drive(input logic v, input logic s, input logic iv, input exp_t x);
    valid = v;
    sof   = s;
    inv   = iv;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic step(input logic v, input logic s, input logic iv);
    exp_t x;
    model_step(v, s, iv, x);
    drive(v, s, iv, x);
  endtask

  task automatic do_reset();
    exp_t x;
    rst   = 1'b1;
    valid = 1'b0;
    sof   = 1'b0;
    model_reset();
    x = '{default: 0};
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
    rst = 1'b0;
  endtask

  initial begin
    int unsigned addr_list[16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
    exp_t        x;
    int unsigned n;
    int unsigned cyc;
    logic        v;

    for (int unsigned i = 0; i < 16; i++)
      tbl[i] = '{sof: (i == 0), addr: 4'(addr_list[i]),
                 trivial: (i <= 4 || i == 8 || i == 12), eof: (i == 15)};

    @(posedge clk);
    #1;
    do_reset();

    // Scenario 1: continuous frame, expectations straight from the table
    for (int unsigned i = 0; i < 16; i++) begin
      model_step(1'b1, tbl[i].sof, 1'b0, x);
      x.addr4   = tbl[i].addr;
      x.trivial = tbl[i].trivial;
      x.sof     = tbl[i].sof;
      x.eof     = tbl[i].eof;
      drive(1'b1, tbl[i].sof, 1'b0, x);
    end

    // Scenario 2: back-to-back frames, forward then conjugated (inverse only at sof)
    for (int unsigned i = 0; i < 16; i++) begin
      step(1'b1, i == 0, 1'b0);
      if (i == 7)  chk("s2_fwd_addr6_s7", a6, 24);
      if (i == 15) chk("s2_fwd_addr6_s15", a6, 36);
    end
    for (int unsigned i = 0; i < 16; i++) begin
      step(1'b1, i == 0, i == 0);
      if (i == 0)  chk("s2_inv_addr6_s0", a6, 0);
      if (i == 7)  chk("s2_inv_addr6_s7", a6, 40);
      if (i == 15) chk("s2_inv_addr6_s15", a6, 28);
    end

    // Scenario 3: random gaps, compressed stream must match the table
    n   = 0;
    cyc = 0;
    while (n < 16 && cyc < 1000) begin
      v = ($urandom_range(0, 99) < 40);
      step(v, v && (n == 0), 1'b0);
      if (v) begin
        chk("s3_addr4", a4, tbl[n].addr);
        n++;
      end
      cyc++;
    end
    chk("s3_samples", n, 16);

    // Scenario 4: inverse toggled at c=6 only takes effect at the next frame
    for (int unsigned i = 0; i < 16; i++) begin
      step(1'b1, i == 0, i >= 6);
      if (i == 7) chk("s4_still_fwd_s7", a6, 24);
    end
    for (int unsigned i = 0; i < 16; i++) begin
      step(1'b1, i == 0, 1'b1);
      if (i == 7) chk("s4_conj_s7", a6, 40);
    end

    // Scenario 5: resync on sof at c=9
    for (int unsigned i = 0; i < 9; i++) step(1'b1, i == 0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("s5_err_pulse", er4, 1);
    chk("s5_resync_addr", a4, 0);
    chk("s5_resync_sof", s4, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("s5_err_cleared", er4, 0);
    for (int unsigned i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    chk("s5_c5_addr4", a4, 2);

    // Scenario 6: reset mid-frame at c=10
    for (int unsigned i = 0; i < 10; i++) step(1'b1, i == 0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    chk("s6_post_rst_sof", s4, 1);
    chk("s6_post_rst_addr", a4, 0);
    for (int unsigned i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
